// File: rtl/memory_access_unit_pkg.sv
// memory_access_pkg: shared widths, FSM encoding and request record for the memory access unit
package memory_access_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 4;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic              is_st;
    logic              is_wb;
  } req_t;
  function automatic logic bad_mem_op(input logic ld, input logic st, input logic [1:0] lsb);
    return (ld & st) | ((ld | st) & (|lsb));
  endfunction
endpackage

// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: execute-stage, data-memory and writeback signals of the memory access unit
interface memory_access_unit_if;
  import memory_access_pkg::*;
  logic              ex_valid, ex_ready;
  logic              isLd, isSt, isWb;
  logic [DATA_W-1:0] aluResult, op2;
  logic [REG_W-1:0]  rd;
  logic              mem_req, mem_we, mem_ack;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              wb_valid, wb_en;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data, ldResult;
  logic              stall, err;
  modport master (
    output ex_valid, isLd, isSt, isWb, aluResult, op2, rd, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_rd, wb_data, ldResult, stall, err
  );
  modport slave (
    input  ex_valid, isLd, isSt, isWb, aluResult, op2, rd, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_rd, wb_data, ldResult, stall, err
  );
endinterface

// File: rtl/memory_access_unit_timeout.sv
// ma_timeout_counter: counts WAIT cycles without ack and flags the last allowed one
module ma_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expire = inc & (cnt_q == W'(LIMIT - 1));
  // clear on WAIT entry, otherwise step once per unanswered WAIT cycle
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: executes ALU writeback, aligned loads/stores with timeout, and illegal-op errors
module memory_access_unit import memory_access_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic reset,
  memory_access_unit_if.slave bus
);
  logic [1:0]        state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] ld_q, ld_d, wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic              wb_valid_q, wb_valid_d, wb_en_q, wb_en_d, err_q, err_d;
  logic              accept, mem_op, illegal, pass, start, in_wait, ack, expire;
  assign accept  = bus.ex_valid & (state_q == S_IDLE);
  assign mem_op  = bus.isLd | bus.isSt;
  assign illegal = bad_mem_op(bus.isLd, bus.isSt, bus.aluResult[1:0]);
  assign pass    = accept & ~mem_op;
  assign start   = accept & mem_op & ~illegal;
  assign in_wait = state_q == S_WAIT;
  assign ack     = in_wait & bus.mem_ack;
  ma_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .reset(reset), .clr(start), .inc(in_wait & ~bus.mem_ack), .expire(expire)
  );
  assign bus.ex_ready  = state_q == S_IDLE;
  assign bus.stall     = ~bus.ex_ready;
  assign bus.mem_req   = in_wait;
  assign bus.mem_we    = in_wait & req_q.is_st;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.ldResult  = ld_q;
  assign bus.err       = err_q;
  // next state; writeback results are registered so they appear in the cycle after accept or ack
  always_comb begin
    state_d    = start ? S_WAIT : ack ? S_DONE : (expire | (state_q == S_DONE)) ? S_IDLE : state_q;
    req_d      = start ? req_t'{addr: bus.aluResult, wdata: bus.op2, rd: bus.rd, is_st: bus.isSt, is_wb: bus.isWb} : req_q;
    ld_d       = ack & ~req_q.is_st ? bus.mem_rdata : ld_q;
    wb_valid_d = pass | ack;
    wb_en_d    = pass ? bus.isWb : ack & ~req_q.is_st & req_q.is_wb;
    wb_rd_d    = pass ? bus.rd : ack ? req_q.rd : wb_rd_q;
    wb_data_d  = pass ? bus.aluResult : ack & ~req_q.is_st ? bus.mem_rdata : wb_data_q;
    err_d      = (accept & illegal) | expire;
  end
  // state registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      ld_q       <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ld_q       <= ld_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      err_q      <= err_d;
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: vector table, directed multi-cycle sequences and random transactions vs a reference model
module tb_memory_access_unit;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  memory_access_unit_if bus();
  memory_access_unit #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_ld = '0;
  typedef struct {
    logic v, ld, st, wb;
    logic [31:0] alu;
    logic [3:0] rd;
    logic e_wbv, e_en, e_err;
    logic [31:0] e_data;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic wb,
                       input logic [31:0] alu, input logic [31:0] op2, input logic [3:0] rd);
    bus.ex_valid = v;
    bus.isLd = ld;
    bus.isSt = st;
    bus.isWb = wb;
    bus.aluResult = alu;
    bus.op2 = op2;
    bus.rd = rd;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // one instruction from IDLE; dly = WAIT cycle on which memory acks (beyond TO means never)
  task automatic txn(input logic ld, input logic st, input logic wb, input logic [31:0] alu,
                     input logic [31:0] op2, input logic [3:0] rd, input int dly);
    logic mem, ill, e_wb, e_err;
    logic [31:0] rdata;
    int lat, c;
    mem = ld | st;
    ill = (ld & st) | (mem & (alu[1:0] != 2'b00));
    rdata = $urandom;
    if (!mem) begin lat = 1; e_wb = 1'b1; e_err = 1'b0; end
    else if (ill) begin lat = 1; e_wb = 1'b0; e_err = 1'b1; end
    else if (dly <= TO) begin lat = dly + 1; e_wb = 1'b1; e_err = 1'b0; end
    else begin lat = TO + 1; e_wb = 1'b0; e_err = 1'b1; end
    drive(1'b1, ld, st, wb, alu, op2, rd);
    bus.mem_ack = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    step;
    idle;
    bus.mem_ack = 1'b0;
    for (c = 1; c <= 60; c++) begin
      if (bus.wb_valid || bus.err) break;
      if (bus.mem_req) begin
        chk("txn mem_addr", bus.mem_addr, alu);
        chk_b("txn mem_we", bus.mem_we, st);
      end
      bus.mem_ack = (c == dly);
      bus.mem_rdata = (c == dly) ? rdata : $urandom;
      step;
    end
    bus.mem_ack = 1'b0;
    chk("txn latency", c, lat);
    chk_b("txn wb_valid", bus.wb_valid, e_wb);
    chk_b("txn err", bus.err, e_err);
    if (e_wb) begin
      chk("txn wb_rd", {28'b0, bus.wb_rd}, {28'b0, rd});
      chk_b("txn wb_en", bus.wb_en, mem ? ld & wb : wb);
      if (!st) chk("txn wb_data", bus.wb_data, mem ? rdata : alu);
      if (ld) model_ld = rdata;
    end
    chk("txn ldResult", bus.ldResult, model_ld);
    step;
    chk_b("txn pulse end", bus.wb_valid | bus.err, 1'b0);
    chk_b("txn back idle", bus.ex_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_002A, 4'd3,  1'b1, 1'b1, 1'b0, 32'h0000_002A};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'd15, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 4'd1,  1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0107, 4'd2,  1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 4'd4,  1'b0, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 4'd6,  1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 4'd9,  1'b1, 1'b1, 1'b0, 32'h0000_0103};
    idle;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    #12;
    chk_b("rst ex_ready", bus.ex_ready, 1'b1);
    chk_b("rst mem_req", bus.mem_req, 1'b0);
    chk_b("rst mem_we", bus.mem_we, 1'b0);
    chk_b("rst wb_valid", bus.wb_valid, 1'b0);
    chk_b("rst wb_en", bus.wb_en, 1'b0);
    chk_b("rst err", bus.err, 1'b0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst wb_data", bus.wb_data, 32'h0);
    chk("rst ldResult", bus.ldResult, 32'h0);
    chk("rst wb_rd", {28'b0, bus.wb_rd}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].wb, vecs[i].alu, 32'h1234_5678, vecs[i].rd);
      step;
      idle;
      chk_b($sformatf("vec%0d wb_valid", i), bus.wb_valid, vecs[i].e_wbv);
      chk_b($sformatf("vec%0d err", i), bus.err, vecs[i].e_err);
      chk_b($sformatf("vec%0d mem_req", i), bus.mem_req, 1'b0);
      chk_b($sformatf("vec%0d ex_ready", i), bus.ex_ready, 1'b1);
      if (vecs[i].e_wbv) begin
        chk($sformatf("vec%0d wb_data", i), bus.wb_data, vecs[i].e_data);
        chk($sformatf("vec%0d wb_rd", i), {28'b0, bus.wb_rd}, {28'b0, vecs[i].rd});
        chk_b($sformatf("vec%0d wb_en", i), bus.wb_en, vecs[i].e_en);
      end
      step;
      chk_b($sformatf("vec%0d pulse", i), bus.wb_valid | bus.err | bus.mem_req, 1'b0);
    end
    bus.mem_ack = 1'b1;
    step;
    bus.mem_ack = 1'b0;
    chk_b("idle ack ignored", bus.mem_req | bus.wb_valid | bus.err, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'd5);
    step;
    idle;
    stall_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      chk_b("load mem_req", bus.mem_req, 1'b1);
      chk_b("load mem_we", bus.mem_we, 1'b0);
      chk("load mem_addr", bus.mem_addr, 32'h100);
      stall_cnt += int'(bus.stall);
      if (c == 3) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
      step;
    end
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    chk_b("load wb_valid", bus.wb_valid, 1'b1);
    chk("load wb_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("load ldResult", bus.ldResult, 32'hDEAD_BEEF);
    chk_b("load wb_en", bus.wb_en, 1'b1);
    chk("load wb_rd", {28'b0, bus.wb_rd}, 32'd5);
    chk_b("load done mem_req", bus.mem_req, 1'b0);
    stall_cnt += int'(bus.stall);
    step;
    chk_b("load stall end", bus.stall, 1'b0);
    chk("load stall cycles", stall_cnt, 4);
    model_ld = 32'hDEAD_BEEF;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h55, 4'd7);
    step;
    idle;
    for (int c = 1; c <= 2; c++) begin
      chk_b("store mem_we", bus.mem_we, 1'b1);
      chk("store mem_wdata", bus.mem_wdata, 32'h55);
      chk("store mem_addr", bus.mem_addr, 32'h104);
      bus.mem_ack = (c == 2);
      step;
    end
    bus.mem_ack = 1'b0;
    chk_b("store wb_valid", bus.wb_valid, 1'b1);
    chk_b("store wb_en", bus.wb_en, 1'b0);
    chk("store wb_rd", {28'b0, bus.wb_rd}, 32'd7);
    chk("store ldResult", bus.ldResult, 32'hDEAD_BEEF);
    step;
    txn(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 4'd2, TO);
    txn(1'b1, 1'b0, 1'b1, 32'h204, 32'h0, 4'd3, 1000);
    txn(1'b0, 1'b1, 1'b0, 32'h208, 32'h99, 4'd4, TO + 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 4'd8);
    step;
    idle;
    chk_b("rstwait mem_req before", bus.mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_b("rstwait mem_req", bus.mem_req, 1'b0);
    chk_b("rstwait ex_ready", bus.ex_ready, 1'b1);
    chk("rstwait mem_addr", bus.mem_addr, 32'h0);
    chk("rstwait ldResult", bus.ldResult, 32'h0);
    model_ld = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk_b("rstwait ready after", bus.ex_ready, 1'b1);
    txn(1'b0, 1'b0, 1'b1, 32'hABC, 32'h0, 4'd1, 0);
    repeat (150) begin
      int kind;
      logic sel, ld, st;
      logic [31:0] alu;
      kind = $urandom_range(0, 4);
      sel = 1'($urandom_range(0, 1));
      alu = $urandom;
      if (kind == 1 || kind == 2) alu[1:0] = 2'b00;
      if (kind == 4) alu[0] = 1'b1;
      ld = (kind == 1) || (kind == 3) || (kind == 4 && sel);
      st = (kind == 2) || (kind == 3) || (kind == 4 && !sel);
      txn(ld, st, 1'($urandom_range(0, 1)), alu, $urandom, 4'($urandom_range(0, 15)), $urandom_range(1, 20));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum number of WAIT cycles before a memory request is abandoned.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately.
REQ-004 ex_valid  in  1  execute stage presents an instruction.
REQ-005 ex_ready  out  1  unit accepts the instruction this cycle.
REQ-006 isLd, isSt, isWb  in  1 each  decoded load, store and register-writeback controls.
REQ-007 aluResult  in  32  ALU result, or effective address for isLd/isSt.
REQ-008 op2  in  32  store data.
REQ-009 rd  in  4  destination register.
REQ-010 mem_req, mem_we  out  1 each  data-memory request and write-enable.
REQ-011 mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-012 mem_ack  in  1  memory completion, sampled only in WAIT.
REQ-013 mem_rdata  in  32  load data, valid when mem_ack==1.
REQ-014 wb_valid, wb_en  out  1 each  result valid for one cycle; writeback enable.
REQ-015 wb_rd  out  4  destination register for the result.
REQ-016 wb_data, ldResult  out  32 each  writeback value; last loaded word.
REQ-017 stall, err  out  1 each  pipeline stall; one-cycle error pulse.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and DONE.
REQ-019 ex_ready SHALL be 1 only in IDLE, and stall SHALL equal the inverse of ex_ready.
REQ-020 IDLE, accept (ex_valid&ex_ready), neither isLd nor isSt: next cycle wb_valid=1, wb_data=aluResult, wb_rd=rd, wb_en=isWb; state stays IDLE (latency 1).
REQ-021 IDLE, accept, exactly one of isLd/isSt, aluResult[1:0]==0: latch address, op2, rd and type; go to WAIT.
REQ-022 WAIT: mem_req=1, mem_we=isSt(latched), mem_addr and mem_wdata SHALL hold their latched values until the ack cycle.
REQ-023 WAIT, mem_ack=1: a load SHALL capture mem_rdata into ldResult; the FSM SHALL go to DONE.
REQ-024 DONE (one cycle): wb_valid=1, wb_rd=latched rd; for a load wb_data=ldResult and wb_en=latched isWb; for a store wb_en=0; then go to IDLE.
REQ-025 Timeout counter SHALL clear on WAIT entry and increment each WAIT cycle without ack.
REQ-026 After TIMEOUT_CYCLES WAIT cycles with no ack: err=1 for one cycle, go to IDLE, no wb_valid, ldResult unchanged.
REQ-027 An ack in the same cycle the count is reached SHALL take priority over the timeout.
REQ-028 Misaligned address (aluResult[1:0]!=0) with isLd or isSt: err=1 next cycle, no mem_req, no wb_valid, stay IDLE.
REQ-029 isLd&isSt both set: treat as illegal, same response as misaligned.
REQ-030 mem_ack outside WAIT SHALL be ignored.
REQ-031 Load/store timing: accept at cycle T, mem_req high T+1..T+k where ack arrives at T+k, wb_valid at T+k+1.
REQ-032 mem_req SHALL be 0 in IDLE and DONE; wb_valid and err SHALL be single-cycle pulses.

Reset
REQ-033 reset==0 SHALL asynchronously set state=IDLE, counter=0, and mem_req, mem_we, wb_valid, wb_en and err to 0.
REQ-034 reset==0 SHALL also clear mem_addr, mem_wdata, wb_data, ldResult and wb_rd to 0.
REQ-035 Reset asserted in WAIT SHALL abandon the request; mem_req SHALL drop without waiting for a clock edge.
REQ-036 First accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-037 Package memory_access_pkg SHALL hold the state encoding, DATA_W=32, REG_W=4 and the TIMEOUT_CYCLES default.
REQ-038 Sub-module ma_timeout_counter SHALL implement the clear/increment/expire counter.

Verification
REQ-039 ALU passthrough: aluResult=0x0000002A, rd=3, isWb=1 -> next cycle wb_valid=1, wb_data=0x2A, wb_rd=3, wb_en=1.
REQ-040 Load: addr=0x100, ack after 3 cycles with mem_rdata=0xDEADBEEF -> wb_data=ldResult=0xDEADBEEF, stall high 4 cycles.
REQ-041 Store: addr=0x104, op2=0x55 -> mem_we=1, mem_wdata=0x55 until ack; wb_en=0 in DONE.
REQ-042 Timeout: load with no ack -> err pulse after 16 WAIT cycles, back to IDLE, ldResult unchanged.
REQ-043 Misaligned load at 0x102 -> err pulse, mem_req never asserted.
REQ-044 Reset pulled low during WAIT -> mem_req=0 immediately, state IDLE, ex_ready=1 after release.
